// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, instruction fields and FSM encodings.
// The opcode values double as the ALU mode encoding, so both sides agree by construction.
package alu_sequencer_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = $clog2(NREG);
    localparam int unsigned IW   = 16;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_NOT   = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_LOADI = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    localparam int unsigned OP_LSB  = 13;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned RS1_LSB = 9;
    localparam int unsigned RS2_LSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    typedef struct packed {
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] imm;
    } instr_t;

    // imm deliberately overlaps the rs2 LSB.
    function automatic instr_t decode(input logic [IW-1:0] raw);
        instr_t d;
        d.op  = raw[OP_LSB  +: 3];
        d.rd  = raw[RD_LSB  +: AW];
        d.rs1 = raw[RS1_LSB +: AW];
        d.rs2 = raw[RS2_LSB +: AW];
        d.imm = raw[IMM_LSB +: DW];
        return d;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/result bus and status flags between fetch/ALU and sequencer.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [2:0]    alu_mode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_out;
    logic          done;
    logic          err;
    logic          busy;

    modport slave (
        input  instr_valid, instr, alu_out,
        output instr_ready, alu_mode, alu_a, alu_b, done, err, busy
    );

    modport master (
        output instr_valid, instr, alu_out,
        input  instr_ready, alu_mode, alu_a, alu_b, done, err, busy
    );

endinterface

// File: rtl/regfile_4x8.sv
// Register file: two async operand read ports, async debug read, one sync write, sync clear on rst.
module regfile_4x8
    import alu_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1   = mem_q[raddr1];
    assign rdata2   = mem_q[raddr2];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue side of the 8-bit ALU: accepts one instruction at a time, drives the ALU and writes back.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus,
    input  logic [AW-1:0]  dbg_addr,
    output logic [DW-1:0]  dbg_data
);

    logic [1:0]    state_q;
    logic [IW-1:0] instr_q;
    logic [DW-1:0] result_q;
    logic [2:0]    alu_mode_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          rf_we;
    instr_t        dec;

    assign dec   = decode(instr_q);
    assign rf_we = (state_q == ST_WB);

    regfile_4x8 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (dec.rd),
        .wdata    (result_q),
        .raddr1   (dec.rs1),
        .rdata1   (rdata1),
        .raddr2   (dec.rs2),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            result_q   <= '0;
            alu_mode_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_alu_op(dec.op)) begin
                        alu_mode_q <= dec.op;
                        alu_a_q    <= rdata1;
                        alu_b_q    <= rdata2;
                        state_q    <= ST_EXEC;
                    end else if (dec.op == OP_LOADI) begin
                        result_q <= dec.imm;
                        state_q  <= ST_WB;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                // Operands were registered last edge, so the ALU has had a full cycle to settle.
                ST_EXEC: begin
                    result_q <= bus.alu_out;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE) && !rst;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.alu_mode    = alu_mode_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural combinational ALU on the ALU bus.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;
    int            n_vec = 0;
    int            n_err = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] m, input logic [7:0] a, b);
        case (m)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            3'd5:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_out = alu_model(bus.alu_mode, bus.alu_a, bus.alu_b);

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd, rs1, rs2);
        return {op, rd, rs1, rs2, 7'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'd6, rd, 3'b000, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("R%0d", idx), dbg_data, exp);
    endtask

    // Issues one instruction; returns edges from acceptance to done and the ALU bus one edge in.
    task automatic issue(input logic [15:0] ins, output int lat,
                         output logic [2:0] m, output logic [7:0] a, output logic [7:0] b);
        int w = 0;
        while (!bus.instr_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.instr_ready) check("ready_timeout", bus.instr_ready, 1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'hE5A5;
        lat = 0; m = '0; a = '0; b = '0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                m = bus.alu_mode; a = bus.alu_a; b = bus.alu_b;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check("done_timeout", bus.done, 1);
    endtask

    task automatic do_loadi(input logic [1:0] rd, input logic [7:0] imm);
        int lat; logic [2:0] m; logic [7:0] a, b;
        issue(ldi(rd, imm), lat, m, a, b);
        check("loadi_lat", lat, 2);
    endtask

    task automatic do_alu(input string tag, input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                          input logic [7:0] ea, eb);
        int lat; logic [2:0] m; logic [7:0] a, b;
        issue(enc(op, rd, rs1, rs2), lat, m, a, b);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_mode"}, m, op);
        check({tag, "_a"}, a, ea);
        check({tag, "_b"}, b, eb);
    endtask

    initial begin
        logic [15:0] ops [3];
        int          acc_cyc [4];
        int          acc, dones, lat;
        logic [2:0]  m;
        logic [7:0]  a, b;

        bus.instr_valid = 1'b0;
        bus.instr       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.instr_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_alu", {bus.alu_mode, bus.alu_a, bus.alu_b}, 0);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.instr_ready, 1);

        // 1: LOADI
        do_loadi(2'd1, 8'h3C);
        do_loadi(2'd2, 8'h0F);
        check_reg(2'd1, 8'h3C);
        check_reg(2'd2, 8'h0F);

        // 2: ADD
        do_alu("add", 3'd0, 2'd3, 2'd1, 2'd2, 8'h3C, 8'h0F);
        check_reg(2'd3, 8'h4B);

        // 3: wrap cases, rd==rs1, NOT
        do_alu("sub", 3'd1, 2'd0, 2'd2, 2'd1, 8'h0F, 8'h3C);
        check_reg(2'd0, 8'hD3);
        do_loadi(2'd1, 8'hFF);
        do_loadi(2'd2, 8'h01);
        do_alu("add_wrap", 3'd0, 2'd1, 2'd1, 2'd2, 8'hFF, 8'h01);
        check_reg(2'd1, 8'h00);
        do_alu("not", 3'd4, 2'd3, 2'd1, 2'd2, 8'h00, 8'h01);
        check_reg(2'd3, 8'hFF);

        // 4: valid held high with three queued ops (R0=D3 R1=00 R2=01 R3=FF)
        ops[0] = enc(3'd2, 2'd1, 2'd0, 2'd3);
        ops[1] = enc(3'd3, 2'd2, 2'd2, 2'd0);
        ops[2] = enc(3'd5, 2'd0, 2'd0, 2'd3);
        acc = 0; dones = 0;
        for (int c = 0; c < 12; c++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = (acc < 3) ? ops[acc] : 16'h0000;
            if (c == 2) check("ready_busy", bus.instr_ready, 0);
            if (bus.instr_ready) begin
                if (acc < 4) acc_cyc[acc] = c;
                acc++;
            end
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        bus.instr_valid = 1'b0;
        check("hold_accepts", acc, 3);
        check("hold_space0", acc_cyc[1] - acc_cyc[0], 4);
        check("hold_space1", acc_cyc[2] - acc_cyc[1], 4);
        check("hold_dones", dones, 3);
        check_reg(2'd0, 8'h2C);
        check_reg(2'd1, 8'hD3);
        check_reg(2'd2, 8'hD3);

        // 5: illegal opcode, then XOR R2 = R1 ^ R3
        issue(enc(3'd7, 2'd0, 2'd0, 2'd0), lat, m, a, b);
        check("ill_lat", lat, 1);
        check("ill_err", bus.err, 1);
        check_reg(2'd0, 8'h2C);
        check_reg(2'd1, 8'hD3);
        check_reg(2'd2, 8'hD3);
        check_reg(2'd3, 8'hFF);
        do_alu("xor", 3'd5, 2'd2, 2'd1, 2'd3, 8'hD3, 8'hFF);
        check_reg(2'd2, 8'h2C);
        check("err_sticky", bus.err, 1);

        // 6: reset during EXEC of an ADD
        bus.instr       = enc(3'd0, 2'd0, 2'd0, 2'd1);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        check("exec_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_ready", bus.instr_ready, 0);
        check("rst_mid_err", bus.err, 0);
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);
        rst = 1'b0;
        #1;
        check("ready_after_rst2", bus.instr_ready, 1);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("no_done_after_rst", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
